// File: rtl/usr_seq_ctrl_pkg.sv
// usr_seq_ctrl_pkg: shared FSM states, USR mode codes and command op codes
package usr_seq_ctrl_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;
    localparam logic [1:0] USR_HOLD = 2'b00;
    localparam logic [1:0] USR_SHR  = 2'b01;
    localparam logic [1:0] USR_SHL  = 2'b10;
    localparam logic [1:0] USR_LOAD = 2'b11;
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_SHR   = 2'b01;
    localparam logic [1:0] OP_SHL   = 2'b10;
    localparam logic [1:0] OP_LDSH  = 2'b11;
    function automatic logic op_loads(input logic [1:0] op);
        return op == OP_LOAD || op == OP_LDSH;
    endfunction
endpackage

// File: rtl/usr_shift_cnt.sv
// usr_shift_cnt: loadable down-counter of remaining shifts with a last-shift flag
//   clk, clear      clock, sync active-high reset
//   i_load, i_val   load the counter with i_val
//   i_dec           decrement by one
//   o_rem, o_last   remaining count, high when o_rem == 1
module usr_shift_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_rem,
    output logic             o_last
);
    logic [CNT_W-1:0] r_rem;
    always_ff @(posedge clk) begin
        if (clear)       r_rem <= '0;
        else if (i_load) r_rem <= i_val;
        else if (i_dec)  r_rem <= r_rem - 1'b1;
    end
    assign o_rem  = r_rem;
    assign o_last = r_rem == CNT_W'(1);
endmodule

// File: rtl/usr_seq_ctrl.sv
// usr_seq_ctrl: command sequencer driving a universal shift register
//   clk, clear                    clock, sync active-high reset (also clears the USR)
//   cmd_valid/cmd_ready           command handshake, accepted only in IDLE
//   cmd_op/cnt/data/rot/fill      command fields
//   usr_q                         USR output fed back
//   usr_s/usr_i/usr_sil/usr_sir   USR mode, parallel input, serial inputs
//   busy, done, result            status, one-cycle completion pulse, captured usr_q
module usr_seq_ctrl
    import usr_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_rot,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] usr_q,
    output logic [1:0]       usr_s,
    output logic [WIDTH-1:0] usr_i,
    output logic             usr_sil,
    output logic             usr_sir,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    state_t           r_state, w_next;
    logic [1:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data, r_result;
    logic             r_rot, r_fill;
    logic             w_accept, w_shift, w_last;
    logic [CNT_W-1:0] w_rem;
    assign w_accept = r_state == ST_IDLE && cmd_valid;
    assign w_shift  = r_state == ST_SHIFT;
    // Loading at accept is equivalent to loading on LOAD->SHIFT: nothing decrements in between.
    usr_shift_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .clear  (clear),
        .i_load (w_accept),
        .i_val  (cmd_cnt),
        .i_dec  (w_shift),
        .o_rem  (w_rem),
        .o_last (w_last)
    );
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_cnt    <= '0;
            r_data   <= '0;
            r_rot    <= 1'b0;
            r_fill   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op   <= cmd_op;
                r_cnt  <= cmd_cnt;
                r_data <= cmd_data;
                r_rot  <= cmd_rot;
                r_fill <= cmd_fill;
            end
            if (r_state == ST_DONE) r_result <= usr_q;
        end
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (cmd_valid) w_next = op_loads(cmd_op) ? ST_LOAD : (cmd_cnt != '0 ? ST_SHIFT : ST_DONE);
            ST_LOAD:  w_next = (r_op == OP_LDSH && r_cnt != '0) ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (w_last) w_next = ST_DONE;
            default:  w_next = ST_IDLE;
        endcase
    end
    always_comb begin
        usr_s   = r_state == ST_LOAD ? USR_LOAD : w_shift ? (r_op == OP_SHL ? USR_SHL : USR_SHR) : USR_HOLD;
        usr_i   = r_state == ST_LOAD ? r_data : '0;
        usr_sir = w_shift & (r_rot ? usr_q[0] : r_fill);
        usr_sil = w_shift & (r_rot ? usr_q[WIDTH-1] : r_fill);
    end
    assign cmd_ready = r_state == ST_IDLE;
    assign busy      = !cmd_ready;
    assign done      = r_state == ST_DONE;
    assign result    = r_result;
    // w_rem is exposed by the counter for debug only.
    logic w_unused;
    assign w_unused = ^w_rem;
endmodule

// File: tb/tb_usr_seq_ctrl.sv
module tb_usr_seq_ctrl;
    logic       clk = 0, clear = 1, cmd_valid = 0, cmd_rot = 0, cmd_fill = 0;
    logic [1:0] cmd_op = 0;
    logic [2:0] cmd_cnt = 0;
    logic [3:0] cmd_data = 0;
    logic       cmd_ready, usr_sil, usr_sir, busy, done;
    logic [1:0] usr_s;
    logic [3:0] usr_i, result, usr_q;
    int total = 0, bad = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    usr_seq_ctrl dut (
        .clk(clk), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .cmd_rot(cmd_rot),
        .cmd_fill(cmd_fill), .usr_q(usr_q), .usr_s(usr_s), .usr_i(usr_i),
        .usr_sil(usr_sil), .usr_sir(usr_sir), .busy(busy), .done(done), .result(result)
    );

    // closed-loop 4-bit universal shift register
    always_ff @(posedge clk)
        usr_q <= clear ? 4'b0 : usr_s == 2'b11 ? usr_i : usr_s == 2'b01 ? {usr_sir, usr_q[3:1]} :
                 usr_s == 2'b10 ? {usr_q[2:0], usr_sil} : usr_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: on accept, precompute every busy cycle's expected outputs and register value
    typedef struct packed {logic [1:0] s; logic [3:0] i; logic sil, sir, dn; logic [3:0] q;} ent_t;
    ent_t sched[$];
    ent_t e;
    logic [3:0] m_q = 0, m_res = 0, q;
    logic sl, sr;

    function automatic ent_t mk(input logic [1:0] s, input logic [3:0] i, input logic sil, input logic sir, input logic dn, input logic [3:0] qq);
        ent_t x;
        x.s = s; x.i = i; x.sil = sil; x.sir = sir; x.dn = dn; x.q = qq;
        return x;
    endfunction

    always @(posedge clk) begin
        if (clear) begin
            sched.delete(); m_q = 0; m_res = 0;
        end else if (sched.size() != 0) begin
            e = sched.pop_front();
            if (e.dn) m_res = e.q;
        end else if (cmd_valid) begin
            q = m_q;
            if (cmd_op == 2'b00 || cmd_op == 2'b11) begin
                sched.push_back(mk(2'b11, cmd_data, 0, 0, 0, q));
                q = cmd_data;
            end
            if (cmd_op != 2'b00)
                for (int k = 0; k < int'(cmd_cnt); k++) begin
                    sr = cmd_rot ? q[0] : cmd_fill;
                    sl = cmd_rot ? q[3] : cmd_fill;
                    sched.push_back(mk(cmd_op == 2'b10 ? 2'b10 : 2'b01, 4'b0, sl, sr, 0, q));
                    q = cmd_op == 2'b10 ? {q[2:0], sl} : {sr, q[3:1]};
                end
            sched.push_back(mk(2'b00, 4'b0, 0, 0, 1, q));
            m_q = q;
        end
    end

    always @(negedge clk) if (chk_en) begin
        e = sched.size() != 0 ? sched[0] : mk(2'b00, 4'b0, 0, 0, 0, m_q);
        chk("cyc_ready", cmd_ready, sched.size() == 0);
        chk("cyc_busy", busy, sched.size() != 0);
        chk("cyc_s", usr_s, e.s);
        chk("cyc_i", usr_i, e.i);
        chk("cyc_sil", usr_sil, e.sil);
        chk("cyc_sir", usr_sir, e.sir);
        chk("cyc_done", done, e.dn);
        chk("cyc_q", usr_q, e.q);
        chk("cyc_result", result, m_res);
    end

    task automatic drive(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data, input logic rot, input logic fill);
        cmd_op = op; cmd_cnt = cnt; cmd_data = data; cmd_rot = rot; cmd_fill = fill; cmd_valid = 1;
        for (int n = 0; n < 50 && !cmd_ready; n++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done(input string name, output int lat, output int ns);
        lat = 1; ns = 0;
        while (!done && lat < 20) begin
            if (usr_s != 2'b00) ns++;
            @(negedge clk);
            lat++;
        end
        if (!done) chk({name, "_done_seen"}, 0, 1);
    endtask

    task automatic issue(input string name, input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data,
                         input logic rot, input logic fill, output int lat, output int ns);
        drive(op, cnt, data, rot, fill);
        cmd_valid = 0;
        wait_done(name, lat, ns);
        @(negedge clk);
    endtask

    initial begin
        int lat, ns;
        bit seen;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_s", usr_s, 0);
        chk("rst_result", result, 0);
        clear = 0;
        chk_en = 1;
        @(negedge clk);
        // 1: LOAD
        issue("t1", 2'b00, 3'd5, 4'b1010, 0, 0, lat, ns);
        chk("t1_lat", lat, 2); chk("t1_scyc", ns, 1); chk("t1_result", result, 4'b1010);
        // 2: LDSH fill=1
        issue("t2", 2'b11, 3'd2, 4'b1001, 0, 1, lat, ns);
        chk("t2_lat", lat, 4); chk("t2_result", result, 4'b1110); chk("t2_model", m_res, 4'b1110);
        // 3: preload then rotate left
        issue("t3pre", 2'b00, 3'd0, 4'b1000, 0, 0, lat, ns);
        issue("t3", 2'b10, 3'd3, 4'b0000, 1, 0, lat, ns);
        chk("t3_lat", lat, 4); chk("t3_scyc", ns, 3); chk("t3_result", result, 4'b0100);
        // 4: SHR cnt=0
        issue("t4pre", 2'b00, 3'd0, 4'b0110, 0, 0, lat, ns);
        issue("t4", 2'b01, 3'd0, 4'b0000, 0, 1, lat, ns);
        chk("t4_lat", lat, 1); chk("t4_scyc", ns, 0); chk("t4_result", result, 4'b0110);
        // 5: clear during 2nd SHIFT cycle
        drive(2'b01, 3'd5, 4'b0000, 0, 1);
        cmd_valid = 0;
        @(negedge clk);
        chk("t5_shifting", usr_s, 2'b01);
        clear = 1;
        @(negedge clk);
        clear = 0;
        chk("t5_busy", busy, 0); chk("t5_s", usr_s, 0); chk("t5_q", usr_q, 0); chk("t5_ready", cmd_ready, 1);
        seen = 0;
        repeat (8) begin @(negedge clk); seen |= done; end
        chk("t5_nodone", seen, 0);
        // 6: cmd_valid held through SHL cnt=2
        drive(2'b10, 3'd2, 4'b0000, 0, 0);
        cmd_op = 2'b00; cmd_data = 4'b0101;
        lat = 1;
        while (!done && lat < 20) begin
            chk("t6_ready_low", cmd_ready, 0);
            @(negedge clk);
            lat++;
        end
        chk("t6_lat", lat, 3);
        @(negedge clk);
        chk("t6_idle_ready", cmd_ready, 1); chk("t6_idle_busy", busy, 0);
        @(negedge clk);
        cmd_valid = 0;
        chk("t6_second_s", usr_s, 2'b11); chk("t6_second_i", usr_i, 4'b0101);
        wait_done("t6b", lat, ns);
        @(negedge clk);
        chk("t6_result", result, 4'b0101);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
